// File: rtl/pixel_framebuffer_writer.sv
// Pixel framebuffer writer: double-buffered frame fill with a fixed two-stage
// address/data pipeline, drop counting and a display-handshake buffer swap.
module pixel_framebuffer_writer #(
  parameter int          H_PIXELS = 320,
  parameter int          V_PIXELS = 180,
  parameter logic [11:0] BG_COLOR = 12'h000,
  localparam int         ADDR_W   = $clog2(H_PIXELS * V_PIXELS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic              block_visible_in,
  input  logic [3:0]        r_in,
  input  logic [3:0]        g_in,
  input  logic [3:0]        b_in,
  input  logic              rgb_valid_in,
  input  logic              frame_start_in,
  input  logic              swap_ack_in,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [11:0]       fb_data_out,
  output logic              fb_we_out,
  output logic              fb_sel_out,
  output logic              display_sel_out,
  output logic              frame_done_out,
  output logic              busy_out,
  output logic [7:0]        drop_count_out
);

  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  TOTAL = CNT_W'(H_PIXELS * V_PIXELS);
  localparam logic [11:0]       X_LIM = 12'(H_PIXELS);
  localparam logic [10:0]       Y_LIM = 11'(V_PIXELS);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_SWAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_base, cnt_inc;
  logic               disp_q, disp_d;
  logic [7:0]         drop_q, drop_d;
  logic               in_bounds, accept, last_d;

  // Stage 1 and stage 2 pipeline registers
  logic               s1_valid_q, s1_last_q;
  logic [ADDR_W-1:0]  s1_row_q, s1_x_q;
  logic [11:0]        s1_data_q;
  logic               s2_we_q, s2_done_q;
  logic [ADDR_W-1:0]  s2_addr_q;
  logic [11:0]        s2_data_q;

  assign in_bounds = ({1'b0, x_in} < X_LIM) && ({1'b0, y_in} < Y_LIM);
  assign accept    = rgb_valid_in && (state_q == FILL) && in_bounds;

  // A start pulse in FILL restarts the count; a coincident pixel becomes the first one.
  assign cnt_base  = (state_q == FILL && frame_start_in) ? '0 : cnt_q;
  assign cnt_inc   = cnt_base + 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        cnt_d = cnt_base;
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TOTAL) begin
            state_d = WAIT_SWAP;
            cnt_d   = '0;
            last_d  = 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (swap_ack_in) begin
          disp_d  = ~disp_q;
          cnt_d   = '0;
          state_d = frame_start_in ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (rgb_valid_in && !accept && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order. The datapath
  // registers are reset too because the address/data outputs have defined
  // reset values, and clearing the valids squashes any in-flight write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      disp_q     <= 1'b0;
      drop_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_row_q   <= '0;
      s1_x_q     <= '0;
      s1_data_q  <= '0;
      s2_we_q    <= 1'b0;
      s2_done_q  <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      drop_q     <= drop_d;
      s1_valid_q <= accept;
      s1_last_q  <= last_d;
      s1_row_q   <= ADDR_W'(y_in * H_PIXELS);
      s1_x_q     <= ADDR_W'(x_in);
      s1_data_q  <= block_visible_in ? {r_in, g_in, b_in} : BG_COLOR;
      s2_we_q    <= s1_valid_q;
      s2_done_q  <= s1_valid_q && s1_last_q;
      s2_addr_q  <= s1_row_q + s1_x_q;
      s2_data_q  <= s1_data_q;
    end
  end

  assign fb_addr_out     = s2_addr_q;
  assign fb_data_out     = s2_data_q;
  assign fb_we_out       = s2_we_q;
  assign frame_done_out  = s2_done_q;
  assign display_sel_out = disp_q;
  assign fb_sel_out      = ~disp_q;
  assign busy_out        = (state_q != IDLE);
  assign drop_count_out  = drop_q;

endmodule

// File: tb/tb_pixel_framebuffer_writer.sv
// Directed testbench for pixel_framebuffer_writer on a 4x2 frame.
module tb_pixel_framebuffer_writer;

  localparam logic [11:0] BG = 12'h5C3;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        vis;
  logic [3:0]  r_in, g_in, b_in;
  logic        valid, start, ack;
  logic [2:0]  fb_addr;
  logic [11:0] fb_data;
  logic        fb_we, fb_sel, disp_sel, done, busy;
  logic [7:0]  drops;

  int total = 0;
  int bad   = 0;

  pixel_framebuffer_writer #(
    .H_PIXELS(4),
    .V_PIXELS(2),
    .BG_COLOR(BG)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .x_in            (x_in),
    .y_in            (y_in),
    .block_visible_in(vis),
    .r_in            (r_in),
    .g_in            (g_in),
    .b_in            (b_in),
    .rgb_valid_in    (valid),
    .frame_start_in  (start),
    .swap_ack_in     (ack),
    .fb_addr_out     (fb_addr),
    .fb_data_out     (fb_data),
    .fb_we_out       (fb_we),
    .fb_sel_out      (fb_sel),
    .display_sel_out (disp_sel),
    .frame_done_out  (done),
    .busy_out        (busy),
    .drop_count_out  (drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_pixel(input int x, input int y, input logic v, input logic [11:0] rgb);
    x_in  = 11'(x);
    y_in  = 10'(y);
    vis   = v;
    {r_in, g_in, b_in} = rgb;
    valid = 1'b1;
  endtask

  task automatic drive_idle();
    valid = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
  endtask

  // Streams n raster-order pixels; each write is checked two cycles after its input.
  task automatic run_pixels(input int n, input int done_idx, input int invis_idx,
                            input logic start_first, input logic [11:0] rgb);
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("we", fb_we, 1);
        check("addr", fb_addr, k - 2);
        check("data", fb_data, (k - 2 == invis_idx) ? BG : rgb);
        check("done", done, (k - 2 == done_idx));
      end else begin
        check("we_idle", fb_we, 0);
      end
      if (k < n) begin
        drive_pixel(k % 4, k / 4, k != invis_idx, rgb);
        start = start_first && (k == 0);
      end else begin
        drive_idle();
      end
    end
  endtask

  task automatic pulse(input logic s, input logic a);
    @(negedge clk);
    start = s;
    ack   = a;
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    int writes;
    rst = 1'b1;
    x_in = '0; y_in = '0; vis = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    drive_idle();

    // Reset values
    @(negedge clk);
    check("rst_we", fb_we, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drops, 0);
    check("rst_disp", disp_sel, 0);
    check("rst_fbsel", fb_sel, 1);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    rst = 1'b0;

    // Full visible frame
    @(negedge clk);
    start = 1'b1;
    run_pixels(8, 7, -1, 1'b0, 12'hF0A);
    check("busy_wait_swap", busy, 1);

    // WAIT_SWAP: lone start ignored, pixel dropped
    pulse(1'b1, 1'b0);
    drive_pixel(0, 0, 1'b1, 12'hFFF);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check("ws_drop", drops, 1);
    check("ws_we0", fb_we, 0);
    @(negedge clk);
    check("ws_we1", fb_we, 0);
    check("ws_busy", busy, 1);

    // Swap, then a second ack in IDLE is ignored
    pulse(1'b0, 1'b1);
    check("swap_disp", disp_sel, 1);
    check("swap_fbsel", fb_sel, 0);
    check("swap_idle", busy, 0);
    pulse(1'b0, 1'b1);
    check("ack_idle_disp", disp_sel, 1);
    check("ack_idle_fbsel", fb_sel, 0);

    // Out-of-bounds drops, then a frame ending in an invisible pixel
    pulse(1'b1, 1'b0);
    drive_pixel(4, 0, 1'b1, 12'hFFF);
    @(negedge clk);
    drive_pixel(0, 2, 1'b1, 12'hFFF);
    @(negedge clk);
    drive_idle();
    check("oob_we0", fb_we, 0);
    check("oob_drop", drops, 3);
    @(negedge clk);
    check("oob_we1", fb_we, 0);
    run_pixels(8, 7, 7, 1'b0, 12'h3C5);
    check("busy_after_invis", busy, 1);

    // Coincident swap and start go straight back to FILL
    pulse(1'b1, 1'b1);
    check("sw_start_disp", disp_sel, 0);
    check("sw_start_fbsel", fb_sel, 1);
    check("sw_start_busy", busy, 1);

    // Restart: 5 pixels, lone start, 3 pixels, then start with the first of 8
    run_pixels(5, -1, -1, 1'b0, 12'h3C5);
    pulse(1'b1, 1'b0);
    run_pixels(3, -1, -1, 1'b0, 12'h3C5);
    run_pixels(8, 7, -1, 1'b1, 12'h3C5);
    pulse(1'b0, 1'b1);
    check("restart_disp", disp_sel, 1);
    check("restart_idle", busy, 0);

    // Reset one cycle after an accepted pixel squashes its write
    pulse(1'b1, 1'b0);
    drive_pixel(0, 0, 1'b1, 12'hABC);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_disp", disp_sel, 0);
    check("mid_rst_fbsel", fb_sel, 1);
    check("mid_rst_addr", fb_addr, 0);
    check("mid_rst_data", fb_data, 0);
    check("mid_rst_drop", drops, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_we", fb_we, 0);

    // Drop-counter saturation while IDLE
    writes = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fb_we) writes++;
      if (i == 254) check("drop254", drops, 254);
      if (i == 255) check("drop255", drops, 255);
      drive_pixel(1, 1, 1'b1, 12'h777);
    end
    @(negedge clk);
    drive_idle();
    if (fb_we) writes++;
    check("sat_drop", drops, 255);
    check("sat_writes", writes, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer_writer.md
PIXEL_FRAMEBUFFER_WRITER -- requirements
Module: pixel_framebuffer_writer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 320, frame width in pixels.
REQ-002 SHALL have parameter V_PIXELS, default 180, frame height in pixels.
REQ-003 SHALL have parameter BG_COLOR, default 12'h000, {r,g,b} color written for non-visible pixels.
REQ-004 SHALL have local ADDR_W = clog2(H_PIXELS*V_PIXELS), which is 16 at the defaults.
REQ-005 SHALL have port clk_in  input  1  system clock; single clock domain.
REQ-006 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port x_in  input  11  pixel column from the shading pipeline.
REQ-008 SHALL have port y_in  input  10  pixel row.
REQ-009 SHALL have port block_visible_in  input  1  pixel covered by a block.
REQ-010 SHALL have ports r_in, g_in, b_in  input  4 each  pixel color.
REQ-011 SHALL have port rgb_valid_in  input  1  pixel qualifier; there is no backpressure.
REQ-012 SHALL have port frame_start_in  input  1  one-cycle pulse that begins filling a frame.
REQ-013 SHALL have port swap_ack_in  input  1  one-cycle pulse from the display at vsync that permits a buffer swap.
REQ-014 SHALL have port fb_addr_out  output  ADDR_W  write address, y*H_PIXELS+x.
REQ-015 SHALL have port fb_data_out  output  12  {r,g,b} write data.
REQ-016 SHALL have port fb_we_out  output  1  write enable.
REQ-017 SHALL have port fb_sel_out  output  1  buffer being written; always equals ~display_sel_out.
REQ-018 SHALL have port display_sel_out  output  1  buffer being scanned out.
REQ-019 SHALL have port frame_done_out  output  1  one-cycle pulse when the frame is complete.
REQ-020 SHALL have port busy_out  output  1  high when state is not IDLE.
REQ-021 SHALL have port drop_count_out  output  8  count of dropped pixels; saturates at 255.

Function
REQ-022 SHALL implement states IDLE, FILL and WAIT_SWAP.
REQ-023 SHALL make these state transitions:
- IDLE to FILL on frame_start_in.
- FILL to WAIT_SWAP when the accepted-pixel count reaches H_PIXELS*V_PIXELS.
- WAIT_SWAP to IDLE on swap_ack_in.
REQ-024 SHALL accept a pixel when rgb_valid_in=1, state=FILL, x_in<H_PIXELS and y_in<V_PIXELS.
REQ-025 SHALL drop a pixel when rgb_valid_in=1 and it is not accepted, whether out of bounds or in IDLE/WAIT_SWAP, and SHALL then increment drop_count_out, saturating at 255.
REQ-026 SHALL give a fixed 2-cycle write latency:
- stage 1 registers inputs and computes y*H_PIXELS;
- stage 2 adds x and drives fb_addr_out, fb_data_out and fb_we_out=1.
REQ-027 SHALL drive fb_data_out={r_in,g_in,b_in} if block_visible_in=1, otherwise BG_COLOR.
REQ-028 SHALL hold fb_we_out=0 on every cycle that does not carry an accepted pixel; fb_addr_out and fb_data_out are then don't-care.
REQ-029 SHALL count every acceptance, so duplicate coordinates count twice; full coverage is the upstream's responsibility.
REQ-030 SHALL enter WAIT_SWAP on the cycle after the final acceptance.
REQ-031 SHALL pulse frame_done_out in the same cycle as the final pixel's fb_we_out, i.e. 2 cycles after its acceptance.
REQ-032 SHALL let in-flight pipeline writes complete after entering WAIT_SWAP or IDLE, still targeting the old fb_sel_out.
REQ-033 SHALL, on swap_ack_in in WAIT_SWAP, toggle display_sel_out on the next edge; fb_sel_out follows.
REQ-034 SHALL ignore swap_ack_in in IDLE and FILL.
REQ-035 SHALL, on frame_start_in in FILL, clear the accepted count and remain in FILL (restart).
REQ-036 SHALL, when frame_start_in is in the same cycle as a pixel in FILL, clear the count and count that pixel as the first of the new frame.
REQ-037 SHALL ignore frame_start_in in WAIT_SWAP, except when it coincides with swap_ack_in; then it swaps and goes directly to FILL with the count cleared.
REQ-038 SHALL size the accepted-pixel counter as ADDR_W+1 bits so it never wraps before the terminal count.

Reset
REQ-039 SHALL, while rst_in=1 at a clock edge, set:
- state IDLE, counter 0;
- pipeline valids 0, fb_we_out=0, frame_done_out=0, busy_out=0;
- drop_count_out=0;
- display_sel_out=0, fb_sel_out=1;
- fb_addr_out=0, fb_data_out=0.
REQ-040 SHALL, on reset mid-FILL, squash any pending pipeline writes, so no fb_we_out pulse follows reset.

Verification (H_PIXELS=4, V_PIXELS=2)
REQ-041 Full frame: after reset and frame_start_in, stream 8 pixels raster-order with rgb=F,0,A, all visible -> 8 writes at addr 0..7, data 12'hF0A, each 2 cycles after its input; frame_done_out coincides with the addr-7 write; busy_out=1.
REQ-042 Invisible pixel: in FILL, (x=3,y=1), block_visible_in=0 -> write addr 7, data BG_COLOR.
REQ-043 Out-of-bounds: in FILL, (x=4,y=0) and (x=0,y=2) -> no fb_we_out, drop_count_out=2, accepted count unchanged.
REQ-044 Swap: in WAIT_SWAP, swap_ack_in -> display_sel_out 0->1, fb_sel_out 1->0, state IDLE; a second swap_ack_in in IDLE -> no change.
REQ-045 Drops and saturation: 300 valid pixels while IDLE -> no writes, drop_count_out=255.
REQ-046 Restart and reset: frame_start_in after 5 pixels -> 8 further pixels are required for frame_done_out; rst_in asserted 1 cycle after an accepted pixel -> no fb_we_out for that pixel, and all outputs at reset values.
